// File: rtl/dl11_fifo_pkg.sv
// Shared constants for the FIFO-buffered DL11 console interface.
// Register indices, the ARM-visible ID word and CSR bit positions.
package dl11_fifo_pkg;

  localparam logic [31:0] DL11_ID = 32'h444C2003;

  typedef enum logic [1:0] {
    ARM_ID  = 2'd0,
    ARM_RX  = 2'd1,
    ARM_TX  = 2'd2,
    ARM_CFG = 2'd3
  } arm_reg_e;

  typedef enum logic [1:0] {
    REG_RCSR = 2'd0,
    REG_RBUF = 2'd1,
    REG_XCSR = 2'd2,
    REG_XBUF = 2'd3
  } bus_reg_e;

  localparam int DONE_BIT  = 7;
  localparam int READY_BIT = 7;
  localparam int IE_BIT    = 6;
  localparam int MAINT_BIT = 2;
  localparam int ERR_BIT   = 15;

endpackage

// File: rtl/dl11_fifo_if.sv
// ARM register window and Unibus slave signals of the DL11 FIFO block.
// The host/bench drives through master; the device uses slave.
interface dl11_fifo_if;
  logic        armwrite;
  logic [1:0]  armraddr;
  logic [1:0]  armwaddr;
  logic [31:0] armwdata;
  logic [31:0] armrdata;
  logic        intreq;
  logic [7:0]  intvec;
  logic [17:0] a_in_h;
  logic [1:0]  c_in_h;
  logic [15:0] d_in_h;
  logic        init_in_h;
  logic        msyn_in_h;
  logic [15:0] d_out_h;
  logic        ssyn_out_h;

  modport master (
    output armwrite, armraddr, armwaddr, armwdata,
    output a_in_h, c_in_h, d_in_h, init_in_h, msyn_in_h,
    input  armrdata, intreq, intvec, d_out_h, ssyn_out_h
  );

  modport slave (
    input  armwrite, armraddr, armwaddr, armwdata,
    input  a_in_h, c_in_h, d_in_h, init_in_h, msyn_in_h,
    output armrdata, intreq, intvec, d_out_h, ssyn_out_h
  );
endinterface

// File: rtl/dl11_sync_fifo.sv
// Single-clock FIFO with wrap-around pointers one bit wider than the index.
// Head is presented combinationally; clr dominates push and pop.
module dl11_sync_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [W-1:0]        mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wp_q, wp_d;
  logic [DEPTH_LOG2:0] rp_q, rp_d;
  logic                do_push;
  logic                do_pop;

  assign count   = wp_q - rp_q;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign dout    = mem[rp_q[DEPTH_LOG2-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_push) wp_d = wp_q + 1'b1;
    if (do_pop)  rp_d = rp_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wp_q[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/dl11_fifo.sv
// DL11 console with RX/TX FIFOs between an ARM host and the Unibus.
// Define DL11_FIFO_MAINT_EN for the XCSR MAINT loopback (XBUF -> RX FIFO).
module dl11_fifo
  import dl11_fifo_pkg::*;
#(
  parameter logic [17:0] ADDR       = 18'o777560,
  parameter logic [7:0]  INTVEC     = 8'o060,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  dl11_fifo_if.slave  bus
);

  logic        clr;
  logic        enable_q, enable_d;
  logic        rie_q, rie_d;
  logic        xie_q, xie_d;
  logic        rxovr_q, rxovr_d;
  logic        ssyn_q, ssyn_d;
  logic [15:0] dout_q, dout_d;
  logic [7:0]  xbuf_q, xbuf_d;

  logic                rx_push, rx_pop, rx_empty, rx_full;
  logic                tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0]          rx_din, rx_dout, tx_dout;
  logic [DEPTH_LOG2:0] rx_count, tx_count;

  logic        sel, wr, odd_byte, bwr, brd;
  bus_reg_e    breg;
  arm_reg_e    wreg, rreg;
  logic        arm_rxpush, arm_rxclr, arm_txpop, arm_cfg;
  logic        xbuf_push, loop, rx_drop, xbuf_ok;
  logic        ready, rirq, xirq;
  logic [15:0] rcsr, xcsr, rbuf, bus_rdata;
  logic        unused_bits;

  assign clr = RESET | bus.init_in_h;

  assign sel = enable_q & (bus.a_in_h[17:3] == ADDR[17:3])
             & bus.msyn_in_h & ~ssyn_q;
  assign breg     = bus_reg_e'(bus.a_in_h[2:1]);
  assign wr       = bus.c_in_h[1];
  assign odd_byte = bus.c_in_h[0] & bus.a_in_h[0];
  assign bwr      = sel & wr & ~odd_byte;
  assign brd      = sel & ~wr;

  assign wreg       = arm_reg_e'(bus.armwaddr);
  assign rreg       = arm_reg_e'(bus.armraddr);
  assign arm_rxpush = bus.armwrite & (wreg == ARM_RX) & bus.armwdata[15];
  assign arm_rxclr  = bus.armwrite & (wreg == ARM_RX) & bus.armwdata[14];
  assign arm_txpop  = bus.armwrite & (wreg == ARM_TX) & bus.armwdata[15];
  assign arm_cfg    = bus.armwrite & (wreg == ARM_CFG);

  assign xbuf_push = bwr & (breg == REG_XBUF);

`ifdef DL11_FIFO_MAINT_EN
  logic maint_q;
  assign loop = maint_q;

  always_ff @(posedge CLOCK) begin
    if (clr) maint_q <= 1'b0;
    else if (bwr && breg == REG_XCSR)
      maint_q <= bus.d_in_h[MAINT_BIT];
  end
`else
  assign loop = 1'b0;
`endif

  // Loopback shares the RX write port; a same-cycle ARM push wins
  assign rx_push = arm_rxpush | (xbuf_push & loop);
  assign rx_din  = arm_rxpush ? bus.armwdata[7:0] : bus.d_in_h[7:0];
  assign rx_pop  = brd & (breg == REG_RBUF);
  assign tx_push = xbuf_push & ~loop;
  assign tx_pop  = arm_txpop;

  assign rx_drop = (arm_rxpush & rx_full)
                 | (xbuf_push & loop & (rx_full | arm_rxpush));
  assign xbuf_ok = xbuf_push &
                   (loop ? (~rx_full & ~arm_rxpush) : ~tx_full);

  dl11_sync_fifo #(.W(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx (
    .clk(CLOCK), .clr(clr), .push(rx_push), .pop(rx_pop),
    .din(rx_din), .dout(rx_dout), .count(rx_count),
    .empty(rx_empty), .full(rx_full)
  );

  dl11_sync_fifo #(.W(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx (
    .clk(CLOCK), .clr(clr), .push(tx_push), .pop(tx_pop),
    .din(bus.d_in_h[7:0]), .dout(tx_dout), .count(tx_count),
    .empty(tx_empty), .full(tx_full)
  );

  assign ready = loop ? ~rx_full : ~tx_full;

  always_comb begin
    rcsr = '0;
    rcsr[ERR_BIT]  = rxovr_q;
    rcsr[DONE_BIT] = ~rx_empty;
    rcsr[IE_BIT]   = rie_q;
    xcsr = '0;
    xcsr[READY_BIT] = ready;
    xcsr[IE_BIT]    = xie_q;
    xcsr[MAINT_BIT] = loop;
    rbuf = rx_empty ? 16'h0 : {rxovr_q, 7'b0, rx_dout};
  end

  always_comb begin
    bus_rdata = '0;
    unique case (breg)
      REG_RCSR: bus_rdata = rcsr;
      REG_RBUF: bus_rdata = rbuf;
      REG_XCSR: bus_rdata = xcsr;
      REG_XBUF: bus_rdata = {8'h0, xbuf_q};
    endcase
  end

  always_comb begin
    bus.armrdata = '0;
    unique case (rreg)
      ARM_ID:  bus.armrdata = DL11_ID;
      ARM_RX:  bus.armrdata = {8'(rx_count), 7'b0, rxovr_q, rcsr};
      ARM_TX:  bus.armrdata = {8'(tx_count), tx_dout, xcsr};
      ARM_CFG: bus.armrdata = {enable_q, 5'b0, INTVEC, ADDR};
    endcase
  end

  assign rirq       = ~rx_empty & rie_q;
  assign xirq       = ready & xie_q;
  assign bus.intreq = rirq | xirq;
  assign bus.intvec = {INTVEC[7:3], ~rirq, 2'b0};

  always_comb begin
    enable_d = enable_q;
    rie_d    = rie_q;
    xie_d    = xie_q;
    rxovr_d  = rxovr_q;
    xbuf_d   = xbuf_q;
    ssyn_d   = ssyn_q;
    dout_d   = dout_q;
    if (arm_cfg)   enable_d = bus.armwdata[31];
    if (arm_rxclr) rxovr_d  = 1'b0;
    if (rx_drop)   rxovr_d  = 1'b1;
    if (bwr && breg == REG_RCSR) rie_d = bus.d_in_h[IE_BIT];
    if (bwr && breg == REG_XCSR) xie_d = bus.d_in_h[IE_BIT];
    if (xbuf_ok) xbuf_d = bus.d_in_h[7:0];
    if (sel) begin
      ssyn_d = 1'b1;
      dout_d = wr ? 16'h0 : bus_rdata;
    end else if (!bus.msyn_in_h) begin
      ssyn_d = 1'b0;
      dout_d = '0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      enable_q <= 1'b0;
      rie_q    <= 1'b0;
      xie_q    <= 1'b0;
      rxovr_q  <= 1'b0;
      ssyn_q   <= 1'b0;
      dout_q   <= '0;
      xbuf_q   <= '0;
    end else if (bus.init_in_h) begin
      enable_q <= enable_d;
      rie_q    <= 1'b0;
      xie_q    <= 1'b0;
      rxovr_q  <= 1'b0;
      ssyn_q   <= 1'b0;
      dout_q   <= '0;
      xbuf_q   <= '0;
    end else begin
      enable_q <= enable_d;
      rie_q    <= rie_d;
      xie_q    <= xie_d;
      rxovr_q  <= rxovr_d;
      ssyn_q   <= ssyn_d;
      dout_q   <= dout_d;
      xbuf_q   <= xbuf_d;
    end
  end

  assign bus.d_out_h    = dout_q;
  assign bus.ssyn_out_h = ssyn_q;

  assign unused_bits = ^{bus.armwdata[30:16], bus.armwdata[13:8],
                         bus.d_in_h[15:8], tx_empty};

endmodule

// File: tb/tb_dl11_fifo.sv
// Bench for dl11_fifo: vector table over ARM/bus operations plus
// hand sequences for overrun, INIT mid-cycle, loopback and reset.
module tb_dl11_fifo;
  import dl11_fifo_pkg::*;

  localparam logic [17:0] BA     = 18'o777560;
  localparam logic [17:0] A_RCSR = BA;
  localparam logic [17:0] A_RBUF = BA + 18'd2;
  localparam logic [17:0] A_XCSR = BA + 18'd4;
  localparam logic [17:0] A_XBUF = BA + 18'd6;
  localparam logic [31:0] CFG_ON  = {1'b1, 5'b0, 8'o060, BA};
  localparam logic [31:0] CFG_OFF = {1'b0, 5'b0, 8'o060, BA};

  typedef enum {V_AWR, V_ARD, V_BWR, V_BRD, V_IRQ} vk_e;
  typedef struct {
    vk_e         k;
    logic [17:0] a;
    logic        bw;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  vec_t        vq[$];
  logic [15:0] expq[$];
  int          nvec = 0;
  int          nerr = 0;
  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] q;

  dl11_fifo_if bus();

  dl11_fifo #(.DEPTH_LOG2(2)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus(bus.slave)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic add(input vk_e k, input logic [17:0] a, input logic bw,
                     input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.k = k; v.a = a; v.bw = bw; v.d = d; v.e = e;
    vq.push_back(v);
  endtask

  task automatic arm_wr(input logic [1:0] idx, input logic [31:0] d);
    bus.armwaddr = idx;
    bus.armwdata = d;
    bus.armwrite = 1'b1;
    tick();
    bus.armwrite = 1'b0;
  endtask

  task automatic arm_rd(input string nm, input logic [1:0] idx,
                        input logic [31:0] e);
    bus.armraddr = idx;
    #1;
    chk(nm, bus.armrdata, e);
  endtask

  task automatic wait_ssyn(input string nm, input logic lvl);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (bus.ssyn_out_h === lvl) ok = 1'b1;
    end
    if (!ok) begin
      nvec++;
      nerr++;
      $display("FAIL %s: ssyn timeout got %b want %b",
               nm, bus.ssyn_out_h, lvl);
    end
  endtask

  task automatic bus_cyc(input string nm, input logic [17:0] a,
                         input logic w, input logic bw,
                         input logic [15:0] d, output logic [15:0] r);
    bus.a_in_h    = a;
    bus.c_in_h    = {w, bw};
    bus.d_in_h    = d;
    bus.msyn_in_h = 1'b1;
    wait_ssyn(nm, 1'b1);
    r = bus.d_out_h;
    bus.msyn_in_h = 1'b0;
    wait_ssyn(nm, 1'b0);
  endtask

  task automatic bus_rd(input string nm, input logic [17:0] a,
                        input logic [15:0] e);
    logic [15:0] r;
    expq.push_back(e);
    bus_cyc(nm, a, 1'b0, 1'b0, 16'h0, r);
    chk(nm, {16'h0, r}, {16'h0, expq.pop_front()});
  endtask

  task automatic bus_wr(input string nm, input logic [17:0] a,
                        input logic bw, input logic [15:0] d);
    logic [15:0] r;
    bus_cyc(nm, a, 1'b1, bw, d, r);
  endtask

  initial begin
    bus.armwrite  = 1'b0;
    bus.armraddr  = 2'd0;
    bus.armwaddr  = 2'd0;
    bus.armwdata  = '0;
    bus.a_in_h    = '0;
    bus.c_in_h    = '0;
    bus.d_in_h    = '0;
    bus.init_in_h = 1'b0;
    bus.msyn_in_h = 1'b0;

    // RX basics, with ARM-side counts
    add(V_AWR, 18'd3, 0, 32'h8000_0000, 0);
    add(V_ARD, 18'd3, 0, 0, CFG_ON);
    add(V_AWR, 18'd1, 0, 32'h0000_8041, 0);
    add(V_AWR, 18'd1, 0, 32'h0000_8042, 0);
    add(V_ARD, 18'd1, 0, 0, 32'h0200_0080);
    add(V_BRD, A_RCSR, 0, 0, 32'h0080);
    add(V_BRD, A_RBUF, 0, 0, 32'h0041);
    add(V_ARD, 18'd1, 0, 0, 32'h0100_0080);
    add(V_BRD, A_RBUF, 0, 0, 32'h0042);
    add(V_BRD, A_RCSR, 0, 0, 32'h0000);
    add(V_ARD, 18'd1, 0, 0, 32'h0000_0000);
    // receive interrupt
    add(V_BWR, A_RCSR, 0, 32'h0040, 0);
    add(V_IRQ, 0, 0, 0, 32'h034);
    add(V_AWR, 18'd1, 0, 32'h0000_8055, 0);
    add(V_IRQ, 0, 0, 0, 32'h130);
    add(V_BRD, A_RBUF, 0, 0, 32'h0055);
    add(V_IRQ, 0, 0, 0, 32'h034);
    // TX fill to full (depth 4), drop, pop
    add(V_BWR, A_XBUF, 0, 32'h0061, 0);
    add(V_BWR, A_XBUF, 0, 32'h0062, 0);
    add(V_BWR, A_XBUF, 0, 32'h0063, 0);
    add(V_BRD, A_XCSR, 0, 0, 32'h0080);
    add(V_BWR, A_XBUF, 0, 32'h0064, 0);
    add(V_BRD, A_XCSR, 0, 0, 32'h0000);
    add(V_BWR, A_XBUF, 0, 32'h0065, 0);
    add(V_ARD, 18'd2, 0, 0, 32'h0461_0000);
    add(V_BRD, A_XBUF, 0, 0, 32'h0064);
    add(V_AWR, 18'd2, 0, 32'h0000_8000, 0);
    add(V_ARD, 18'd2, 0, 0, 32'h0362_0080);
    add(V_BRD, A_XCSR, 0, 0, 32'h0080);
    add(V_BWR, A_XBUF + 18'd1, 1, 32'h6600, 0);
    add(V_ARD, 18'd2, 0, 0, 32'h0362_0080);
    // both interrupt sources, receive has priority
    add(V_BWR, A_XCSR, 0, 32'h0040, 0);
    add(V_IRQ, 0, 0, 0, 32'h134);
    add(V_AWR, 18'd1, 0, 32'h0000_8077, 0);
    add(V_IRQ, 0, 0, 0, 32'h130);
    add(V_BRD, A_RBUF, 0, 0, 32'h0077);
    add(V_IRQ, 0, 0, 0, 32'h134);
    // odd-byte CSR write changes nothing
    add(V_BWR, A_RCSR + 18'd1, 1, 32'h0000, 0);
    add(V_BRD, A_RCSR, 0, 0, 32'h0040);
    add(V_BRD, A_XCSR, 0, 0, 32'h00C0);

    repeat (3) tick();
    chk("rst_ssyn", {31'b0, bus.ssyn_out_h}, 32'h0);
    chk("rst_dout", {16'b0, bus.d_out_h}, 32'h0);
    chk("rst_irq", {31'b0, bus.intreq}, 32'h0);
    arm_rd("rst_cfg", 2'd3, CFG_OFF);
    arm_rd("rst_id", 2'd0, DL11_ID);
    RESET = 1'b0;
    tick();

    for (int i = 0; i < vq.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      case (vq[i].k)
        V_AWR: arm_wr(vq[i].a[1:0], vq[i].d);
        V_ARD: arm_rd(nm, vq[i].a[1:0], vq[i].e);
        V_BWR: bus_wr(nm, vq[i].a, vq[i].bw, vq[i].d[15:0]);
        V_BRD: bus_rd(nm, vq[i].a, vq[i].e[15:0]);
        V_IRQ: chk(nm, {23'b0, bus.intreq, bus.intvec}, vq[i].e);
      endcase
    end

    // RX full: ARM push in the same cycle as an RBUF read
    arm_wr(2'd1, 32'h8031);
    arm_wr(2'd1, 32'h8032);
    arm_wr(2'd1, 32'h8033);
    arm_wr(2'd1, 32'h8034);
    arm_rd("rx_full", 2'd1, 32'h0400_00C0);
    bus.armwaddr  = 2'd1;
    bus.armwdata  = 32'h8035;
    bus.armwrite  = 1'b1;
    bus.a_in_h    = A_RBUF;
    bus.c_in_h    = 2'b00;
    bus.msyn_in_h = 1'b1;
    expq.push_back(16'h0031);
    tick();
    bus.armwrite = 1'b0;
    chk("ovr_ssyn", {31'b0, bus.ssyn_out_h}, 32'h1);
    chk("ovr_rbuf", {16'h0, bus.d_out_h}, {16'h0, expq.pop_front()});
    bus.msyn_in_h = 1'b0;
    tick();
    arm_rd("ovr_set", 2'd1, 32'h0301_80C0);
    bus_rd("ovr_rbuf2", A_RBUF, 16'h8032);
    arm_wr(2'd1, 32'h0000_4000);
    arm_rd("ovr_clr", 2'd1, 32'h0200_00C0);

    // INIT while a slave cycle is in progress
    bus.a_in_h    = A_RCSR;
    bus.c_in_h    = 2'b00;
    bus.msyn_in_h = 1'b1;
    tick();
    chk("init_pre", {31'b0, bus.ssyn_out_h}, 32'h1);
    bus.init_in_h = 1'b1;
    tick();
    chk("init_ssyn", {31'b0, bus.ssyn_out_h}, 32'h0);
    chk("init_dout", {16'b0, bus.d_out_h}, 32'h0);
    bus.init_in_h = 1'b0;
    bus.msyn_in_h = 1'b0;
    tick();
    arm_rd("init_rx", 2'd1, 32'h0);
    bus.armraddr = 2'd2;
    #1;
    chk("init_tx", bus.armrdata & 32'hFF00_FFFF, 32'h0000_0080);
    arm_rd("init_en", 2'd3, CFG_ON);
    chk("init_irq", {23'b0, bus.intreq, bus.intvec}, 32'h034);

`ifdef DL11_FIFO_MAINT_EN
    bus_wr("mnt_set", A_XCSR, 1'b0, 16'h0004);
    bus_rd("mnt_xcsr", A_XCSR, 16'h0084);
    bus_wr("mnt_xbuf", A_XBUF, 1'b0, 16'o0123);
    bus_rd("mnt_rbuf", A_RBUF, 16'o0123);
    bus.armraddr = 2'd2;
    #1;
    chk("mnt_txcnt", {24'h0, bus.armrdata[31:24]}, 32'h0);
`else
    bus_wr("mnt_set", A_XCSR, 1'b0, 16'h0004);
    bus_rd("mnt_xcsr", A_XCSR, 16'h0080);
`endif

    // RESET clears enable; the bus then goes unanswered
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    arm_rd("rst2_cfg", 2'd3, CFG_OFF);
    arm_rd("rst2_rx", 2'd1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
